// File: rtl/serial_pkg.sv
// Shared definitions for the serial line transmitter and receiver.
// Line-state encodings, line levels and the frame geometry constants.
package serial_pkg;

    typedef enum logic [1:0] {
        LineIdle  = 2'd0,
        LineStart = 2'd1,
        LineData  = 2'd2,
        LineStop  = 2'd3
    } line_state_e;

    typedef enum logic {
        HReady = 1'b0,
        HWait  = 1'b1
    } hs_state_e;

    localparam logic        START_BIT          = 1'b0;
    localparam logic        STOP_LEVEL         = 1'b1;
    localparam int unsigned DEFAULT_BIT_CLOCKS = 16;
    localparam int unsigned DATA_BITS          = 8;
    localparam int unsigned COUNT_W            = 4;

endpackage

// File: rtl/serial_bit_timer.sv
// Loadable bit-period down-counter; stops at zero and flags it.
module serial_bit_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/serial_transmitter.sv
// Byte-wide four-phase producer interface feeding an 8N1/8N2 serial line.
// The handshake and line FSMs communicate only through the FULL flag and HOLD byte.
module serial_transmitter
    import serial_pkg::*;
#(
    parameter int unsigned BIT_CLOCKS = DEFAULT_BIT_CLOCKS,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic       clock,
    input  logic       reset_,
    input  logic       dav_,
    input  logic [7:0] byte_i,
    output logic       rfd,
    output logic       txd,
    output logic       busy
);

    localparam int unsigned        TimerW     = $clog2(STOP_BITS * BIT_CLOCKS);
    localparam logic [TimerW-1:0]  BitReload  = TimerW'(BIT_CLOCKS - 1);
    localparam logic [TimerW-1:0]  StopReload = TimerW'(STOP_BITS * BIT_CLOCKS - 1);
    localparam logic [COUNT_W-1:0] DataCount  = COUNT_W'(DATA_BITS);

    hs_state_e   hs_q, hs_d;
    logic        rfd_q, rfd_d;
    logic        capture;
    logic        full_q;
    logic [7:0]  hold_q;

    line_state_e        line_q, line_d;
    logic [7:0]         shift_q, shift_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               txd_q, txd_d;
    logic               busy_q, busy_d;
    logic               load_hold;
    logic               tmr_load;
    logic [TimerW-1:0]  tmr_value;
    logic               tmr_zero;

    // Producer handshake
    always_comb begin
        hs_d    = hs_q;
        rfd_d   = rfd_q;
        capture = 1'b0;
        case (hs_q)
            HReady: begin
                if (!dav_ && !full_q) begin
                    capture = 1'b1;
                    rfd_d   = 1'b0;
                    hs_d    = HWait;
                end
            end
            HWait: begin
                if (dav_ && !full_q) begin
                    rfd_d = 1'b1;
                    hs_d  = HReady;
                end
            end
            default: hs_d = HReady;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset_) begin
            hs_q  <= HReady;
            rfd_q <= 1'b1;
        end else begin
            hs_q  <= hs_d;
            rfd_q <= rfd_d;
        end
    end

    // Capture and HOLD load never coincide: capture needs FULL clear, a load needs it set.
    always_ff @(posedge clock) begin
        if (reset_) begin
            full_q <= 1'b0;
        end else if (capture) begin
            full_q <= 1'b1;
        end else if (load_hold) begin
            full_q <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (capture) begin
            hold_q <= byte_i;
        end
    end

    // Line framing
    always_comb begin
        line_d    = line_q;
        shift_d   = shift_q;
        count_d   = count_q;
        txd_d     = txd_q;
        busy_d    = busy_q;
        load_hold = 1'b0;
        tmr_load  = 1'b0;
        tmr_value = BitReload;
        case (line_q)
            LineIdle: begin
                load_hold = full_q;
            end
            LineStart: begin
                if (tmr_zero) begin
                    txd_d    = shift_q[0];
                    count_d  = DataCount;
                    tmr_load = 1'b1;
                    line_d   = LineData;
                end
            end
            LineData: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    if (count_q == COUNT_W'(1)) begin
                        txd_d     = STOP_LEVEL;
                        tmr_value = StopReload;
                        line_d    = LineStop;
                    end else begin
                        shift_d = shift_q >> 1;
                        count_d = count_q - COUNT_W'(1);
                        txd_d   = shift_q[1];
                    end
                end
            end
            LineStop: begin
                if (tmr_zero) begin
                    if (full_q) begin
                        load_hold = 1'b1;
                    end else begin
                        busy_d = 1'b0;
                        line_d = LineIdle;
                    end
                end
            end
            default: line_d = LineIdle;
        endcase
        // Shared frame start for both the idle and back-to-back paths.
        if (load_hold) begin
            shift_d  = hold_q;
            txd_d    = START_BIT;
            busy_d   = 1'b1;
            tmr_load = 1'b1;
            line_d   = LineStart;
        end
    end

    always_ff @(posedge clock) begin
        if (reset_) begin
            line_q  <= LineIdle;
            count_q <= '0;
            txd_q   <= STOP_LEVEL;
            busy_q  <= 1'b0;
        end else begin
            line_q  <= line_d;
            count_q <= count_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clock) begin
        shift_q <= shift_d;
    end

    serial_bit_timer #(
        .WIDTH (TimerW)
    ) u_bit_timer (
        .clk_i   (clock),
        .rst_i   (reset_),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .zero_o  (tmr_zero)
    );

    assign rfd  = rfd_q;
    assign txd  = txd_q;
    assign busy = busy_q;

endmodule
